// File: rtl/hs32_seq_checker_pkg.sv
// Shared encodings for the HS32 register-write sequence checker.
// Pure definitions: no latency, no flow control.
package hs32_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_FAULT    = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_MISMATCH = 2'd3;

    // Table address width; a single-entry table still needs one address bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hs32_chk_table.sv
// Expectation table: NUM_CHECKS x {idx,value,mask}, one write port, combinational read.
// Write lands on the next edge, read is same-cycle; no backpressure.
module hs32_chk_table
    import hs32_seq_checker_pkg::*;
#(
    parameter int NUM_CHECKS = 8,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 4,
    parameter int AW         = addr_w(NUM_CHECKS),
    parameter int SW         = $clog2(NUM_CHECKS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wvalue,
    input  logic [DATA_W-1:0] wmask,
    input  logic [SW-1:0]     raddr,
    output logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rvalue,
    output logic [DATA_W-1:0] rmask
);

    logic [IDX_W-1:0]  idx_q   [NUM_CHECKS];
    logic [DATA_W-1:0] value_q [NUM_CHECKS];
    logic [DATA_W-1:0] mask_q  [NUM_CHECKS];

    // Addresses beyond the table depth match no entry and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                idx_q[i]   <= '0;
                value_q[i] <= '0;
                mask_q[i]  <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (waddr == AW'(i)) begin
                    idx_q[i]   <= widx;
                    value_q[i] <= wvalue;
                    mask_q[i]  <= wmask;
                end
            end
        end
    end

    always_comb begin
        ridx   = '0;
        rvalue = '0;
        rmask  = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (raddr == SW'(i)) begin
                ridx   = idx_q[i];
                rvalue = value_q[i];
                rmask  = mask_q[i];
            end
        end
    end

endmodule

// File: rtl/hs32_seq_checker.sv
// In-order regfile-write sequence checker: matches a programmed table, flags pass/fault/timeout.
// Status registered, visible one cycle after the causing event; snoop-only, never stalls the core.
module hs32_seq_checker
    import hs32_seq_checker_pkg::*;
#(
    parameter int NUM_CHECKS = 8,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 4,
    parameter int TMO_W      = 16,
    parameter bit STRICT     = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_we,
    input  logic [addr_w(NUM_CHECKS)-1:0]   cfg_addr,
    input  logic [IDX_W-1:0]                cfg_idx,
    input  logic [DATA_W-1:0]               cfg_value,
    input  logic [DATA_W-1:0]               cfg_mask,
    input  logic [$clog2(NUM_CHECKS):0]     cfg_count,
    input  logic [TMO_W-1:0]                tmo_limit,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            fault_in,
    input  logic                            rf_we,
    input  logic [IDX_W-1:0]                rf_idx,
    input  logic [DATA_W-1:0]               rf_data,
    output logic                            busy,
    output logic                            pass,
    output logic                            fail,
    output logic [1:0]                      fail_code,
    output logic [$clog2(NUM_CHECKS):0]     step
);

    localparam int AW = addr_w(NUM_CHECKS);
    localparam int SW = $clog2(NUM_CHECKS) + 1;
    localparam logic [SW-1:0] MAX_CNT = SW'(NUM_CHECKS);

    chk_state_t        state_q;
    logic [SW-1:0]     step_q;
    logic [SW-1:0]     count_q;
    logic [TMO_W-1:0]  timer_q;
    logic [1:0]        fail_code_q;
    logic              busy_q;
    logic              pass_q;
    logic              fail_q;

    logic              tbl_we;
    logic [IDX_W-1:0]  exp_idx;
    logic [DATA_W-1:0] exp_value;
    logic [DATA_W-1:0] exp_mask;

    logic              idx_hit;
    logic              hit;
    logic              tmo_hit;
    logic              timer_sat;
    logic [SW-1:0]     step_inc;
    logic [SW-1:0]     start_count;

    // Table is frozen while a run is in progress.
    assign tbl_we = cfg_we && (state_q != ST_RUN);

    hs32_chk_table #(
        .NUM_CHECKS (NUM_CHECKS),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .AW         (AW),
        .SW         (SW)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (tbl_we),
        .waddr  (cfg_addr),
        .widx   (cfg_idx),
        .wvalue (cfg_value),
        .wmask  (cfg_mask),
        .raddr  (step_q),
        .ridx   (exp_idx),
        .rvalue (exp_value),
        .rmask  (exp_mask)
    );

    assign idx_hit     = rf_we && (rf_idx == exp_idx);
    assign hit         = idx_hit && (((rf_data ^ exp_value) & exp_mask) == '0);
    assign step_inc    = step_q + SW'(1);
    assign timer_sat   = &timer_q;
    assign tmo_hit     = (tmo_limit != '0) && (timer_q == (tmo_limit - TMO_W'(1)));
    assign start_count = (cfg_count > MAX_CNT) ? MAX_CNT : cfg_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            fail_code_q <= FC_NONE;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Budget covers the whole run, so the timer never restarts per step.
                    if (!timer_sat) begin
                        timer_q <= timer_q + TMO_W'(1);
                    end
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (fault_in) begin
                        state_q     <= ST_FAIL;
                        busy_q      <= 1'b0;
                        fail_q      <= 1'b1;
                        fail_code_q <= FC_FAULT;
                    end else if (hit) begin
                        step_q <= step_inc;
                        if (step_inc == count_q) begin
                            state_q <= ST_PASS;
                            busy_q  <= 1'b0;
                            pass_q  <= 1'b1;
                        end
                    end else if (STRICT && idx_hit) begin
                        state_q     <= ST_FAIL;
                        busy_q      <= 1'b0;
                        fail_q      <= 1'b1;
                        fail_code_q <= FC_MISMATCH;
                    end else if (tmo_hit) begin
                        state_q     <= ST_FAIL;
                        busy_q      <= 1'b0;
                        fail_q      <= 1'b1;
                        fail_code_q <= FC_TIMEOUT;
                    end
                end
                default: begin
                    if (start) begin
                        count_q     <= start_count;
                        step_q      <= '0;
                        timer_q     <= '0;
                        fail_code_q <= FC_NONE;
                        fail_q      <= 1'b0;
                        if (start_count == '0) begin
                            state_q <= ST_PASS;
                            busy_q  <= 1'b0;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign step      = step_q;

endmodule

// File: tb/tb_hs32_seq_checker.sv
// Scoreboard bench: a lax and a strict checker share stimulus; expected status is queued per step.
module tb_hs32_seq_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_idx;
    logic [31:0] cfg_value;
    logic [31:0] cfg_mask;
    logic [3:0]  cfg_count;
    logic [15:0] tmo_limit;
    logic        start;
    logic        abort;
    logic        fault_in;
    logic        rf_we;
    logic [3:0]  rf_idx;
    logic [31:0] rf_data;

    logic        busy_l, pass_l, fail_l, busy_s, pass_s, fail_s;
    logic [1:0]  code_l, code_s;
    logic [3:0]  step_l, step_s;

    always #5 clk = ~clk;

    hs32_seq_checker #(.STRICT(1'b0)) dut_lax (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_idx(cfg_idx),
        .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_count(cfg_count), .tmo_limit(tmo_limit),
        .start(start), .abort(abort), .fault_in(fault_in), .rf_we(rf_we), .rf_idx(rf_idx),
        .rf_data(rf_data), .busy(busy_l), .pass(pass_l), .fail(fail_l), .fail_code(code_l),
        .step(step_l)
    );

    hs32_seq_checker #(.STRICT(1'b1)) dut_strict (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_idx(cfg_idx),
        .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_count(cfg_count), .tmo_limit(tmo_limit),
        .start(start), .abort(abort), .fault_in(fault_in), .rf_we(rf_we), .rf_idx(rf_idx),
        .rf_data(rf_data), .busy(busy_s), .pass(pass_s), .fail(fail_s), .fail_code(code_s),
        .step(step_s)
    );

    wire [8:0] st_l = {busy_l, pass_l, fail_l, code_l, step_l};
    wire [8:0] st_s = {busy_s, pass_s, fail_s, code_s, step_s};

    typedef struct {
        string      tag;
        bit         sel;
        logic [8:0] st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got {busy,pass,fail,code,step}=%b expected %b", tag, got, exp);
        end
    endtask

    // Expectations are pushed right after the driving edge and consumed on the following negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("%s%s", mon_e.tag, mon_e.sel ? "/strict" : "/lax"),
                  mon_e.sel ? st_s : st_l, mon_e.st);
        end
    end

    task automatic push_exp(input string tag, input bit sel, input logic b, input logic p,
                            input logic f, input logic [1:0] c, input logic [3:0] s);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.st  = {b, p, f, c, s};
        exp_q.push_back(e);
    endtask

    task automatic exp_both(input string tag, input logic b, input logic p, input logic f,
                            input logic [1:0] c, input logic [3:0] s);
        push_exp(tag, 1'b0, b, p, f, c, s);
        push_exp(tag, 1'b1, b, p, f, c, s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [3:0] idx, input logic [31:0] val,
                             input logic [31:0] mask);
        cfg_we = 1'b1; cfg_addr = a; cfg_idx = idx; cfg_value = val; cfg_mask = mask;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] cnt);
        cfg_count = cnt; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rf_write(input logic [3:0] idx, input logic [31:0] data);
        rf_we = 1'b1; rf_idx = idx; rf_data = data;
        tick();
        rf_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_idx = '0; cfg_value = '0; cfg_mask = '0;
        cfg_count = '0; tmo_limit = '0; start = 1'b0; abort = 1'b0; fault_in = 1'b0;
        rf_we = 1'b0; rf_idx = '0; rf_data = '0;
        tick(); tick();
        exp_both("reset", 0, 0, 0, 2'd0, 4'd0);
        reset = 1'b0;
        tick();

        // In-order r0/r1/r2 chain
        cfg_write(3'd0, 4'd0, 32'hCAFE, 32'hFFFF_FFFF);
        cfg_write(3'd1, 4'd1, 32'd5,    32'hFFFF_FFFF);
        cfg_write(3'd2, 4'd2, 32'hCAFE, 32'hFFFF_FFFF);
        do_start(4'd3);            exp_both("inord_start", 1, 0, 0, 2'd0, 4'd0);
        rf_write(4'd0, 32'hCAFE);  exp_both("inord_r0",    1, 0, 0, 2'd0, 4'd1);
        rf_write(4'd1, 32'd5);     exp_both("inord_r1",    1, 0, 0, 2'd0, 4'd2);
        rf_write(4'd3, 32'h1111);  exp_both("inord_other", 1, 0, 0, 2'd0, 4'd2);
        rf_write(4'd2, 32'hCAFE);  exp_both("inord_pass",  0, 1, 0, 2'd0, 4'd3);

        // Out of order: early r1 is ignored, only the rewrite after r0 counts
        do_start(4'd3);            exp_both("ooo_start",   1, 0, 0, 2'd0, 4'd0);
        rf_write(4'd1, 32'd5);     exp_both("ooo_early_r1", 1, 0, 0, 2'd0, 4'd0);
        rf_write(4'd0, 32'hCAFE);  exp_both("ooo_r0",      1, 0, 0, 2'd0, 4'd1);
        rf_write(4'd2, 32'hCAFE);  exp_both("ooo_early_r2", 1, 0, 0, 2'd0, 4'd1);
        rf_write(4'd1, 32'd5);     exp_both("ooo_r1",      1, 0, 0, 2'd0, 4'd2);
        rf_write(4'd2, 32'hCAFE);  exp_both("ooo_pass",    0, 1, 0, 2'd0, 4'd3);

        // Wrong data on the expected index; then abort
        do_start(4'd3);
        rf_write(4'd0, 32'hBEEF);
        push_exp("mism", 1'b0, 1, 0, 0, 2'd0, 4'd0);
        push_exp("mism", 1'b1, 0, 0, 1, 2'd3, 4'd0);
        rf_write(4'd0, 32'hCAFE);
        push_exp("mism_sticky", 1'b0, 1, 0, 0, 2'd0, 4'd1);
        push_exp("mism_sticky", 1'b1, 0, 0, 1, 2'd3, 4'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        push_exp("abort", 1'b0, 0, 0, 0, 2'd0, 4'd1);
        push_exp("abort", 1'b1, 0, 0, 1, 2'd3, 4'd0);

        // Timeout exactly 100 cycles after the start edge
        tmo_limit = 16'd100;
        do_start(4'd3);
        for (int k = 1; k < 100; k++) tick();
        exp_both("tmo_edge_minus1", 1, 0, 0, 2'd0, 4'd0);
        tick();
        exp_both("tmo_fire", 0, 0, 1, 2'd2, 4'd0);
        tmo_limit = 16'd0;

        // Fault outranks a simultaneous match
        do_start(4'd3);
        fault_in = 1'b1; rf_we = 1'b1; rf_idx = 4'd0; rf_data = 32'hCAFE;
        tick();
        fault_in = 1'b0; rf_we = 1'b0;
        exp_both("fault_vs_match", 0, 0, 1, 2'd1, 4'd0);

        // Masked compare on the low half only
        cfg_write(3'd0, 4'd4, 32'h0000_1234, 32'h0000_FFFF);
        do_start(4'd1);
        rf_write(4'd4, 32'hABCD_1234);
        exp_both("mask_pass", 0, 1, 0, 2'd0, 4'd1);

        // Empty run passes immediately
        do_start(4'd0);
        exp_both("count0_pass", 0, 1, 0, 2'd0, 4'd0);

        // Oversized count clamps to the table depth
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 4'(i), 32'h100 + i, 32'hFFFF_FFFF);
        do_start(4'd15);
        for (int i = 0; i < 7; i++) rf_write(4'(i), 32'h100 + i);
        exp_both("clamp_step7", 1, 0, 0, 2'd0, 4'd7);
        rf_write(4'd7, 32'h107);
        exp_both("clamp_pass", 0, 1, 0, 2'd0, 4'd8);

        // Table writes during RUN are dropped
        do_start(4'd1);
        cfg_write(3'd0, 4'd0, 32'h55, 32'hFFFF_FFFF);
        rf_write(4'd0, 32'h100);
        exp_both("cfg_drop", 0, 1, 0, 2'd0, 4'd1);

        // Reset mid-run at step 2 clears status and table
        cfg_write(3'd0, 4'd9,  32'd1, 32'hFFFF_FFFF);
        cfg_write(3'd1, 4'd10, 32'd2, 32'hFFFF_FFFF);
        cfg_write(3'd2, 4'd11, 32'd3, 32'hFFFF_FFFF);
        do_start(4'd3);
        rf_write(4'd9, 32'd1);
        rf_write(4'd10, 32'd2);
        exp_both("pre_reset_step2", 1, 0, 0, 2'd0, 4'd2);
        tick();
        reset = 1'b1;
        exp_both("midrun_reset", 0, 0, 0, 2'd0, 4'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        tick();
        // A cleared entry 0 is {idx 0, mask 0}: any r0 write matches, r9 does not
        do_start(4'd1);
        rf_write(4'd9, 32'd1);
        exp_both("cleared_r9_ignored", 1, 0, 0, 2'd0, 4'd0);
        rf_write(4'd0, 32'hDEAD);
        exp_both("cleared_r0_match", 0, 1, 0, 2'd0, 4'd1);

        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
